// File: rtl/kronos_ex_memctrl.sv
// Execute-stage memory controller: retires ALU writebacks in one cycle and runs
// single-word load/store transactions with an ack timeout.
module kronos_ex_memctrl #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        decode_vld,
    output logic        decode_rdy,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        regwr_alu,
    input  logic [4:0]  rd,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic [31:0] data_addr,
    output logic [31:0] data_wr_data,
    output logic        data_wr_en,
    output logic        data_req,
    input  logic        data_ack,
    input  logic [31:0] data_rd_data,
    output logic [31:0] regwr_data,
    output logic [4:0]  regwr_sel,
    output logic        regwr_en,
    output logic        mem_err
);

    typedef enum logic {
        STEADY = 1'b0,
        MEM    = 1'b1
    } state_e;

    localparam logic [7:0] LAST_CNT = 8'(WAIT_LIMIT - 1);

    state_e      state_q;
    logic        req_q;
    logic        wr_en_q;
    logic        is_store_q;
    logic        regwr_en_q;
    logic        mem_err_q;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] regwr_data_q;
    logic [4:0]  regwr_sel_q;

    logic mem_op;
    logic store_kind;
    logic accept_mem;
    logic accept_alu;
    logic mem_done;

    // A simultaneous load+store flag decodes as a load.
    assign mem_op     = is_load || is_store;
    assign store_kind = is_store && !is_load;
    assign accept_mem = (state_q == STEADY) && decode_vld && mem_op;
    assign accept_alu = (state_q == STEADY) && decode_vld && regwr_alu && !mem_op;
    assign mem_done   = (state_q == MEM) && data_ack;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q    <= STEADY;
            req_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            is_store_q <= 1'b0;
            regwr_en_q <= 1'b0;
            mem_err_q  <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            regwr_en_q <= 1'b0;
            mem_err_q  <= 1'b0;
            case (state_q)
                STEADY: begin
                    if (accept_mem) begin
                        state_q    <= MEM;
                        req_q      <= 1'b1;
                        wr_en_q    <= store_kind;
                        is_store_q <= store_kind;
                        cnt_q      <= 8'd0;
                    end else if (accept_alu) begin
                        regwr_en_q <= (rd != 5'd0);
                    end
                end
                MEM: begin
                    // An ack in the final wait cycle wins over the timeout.
                    if (data_ack) begin
                        state_q    <= STEADY;
                        req_q      <= 1'b0;
                        wr_en_q    <= 1'b0;
                        regwr_en_q <= !is_store_q && (rd_q != 5'd0);
                    end else if (cnt_q == LAST_CNT) begin
                        state_q   <= STEADY;
                        req_q     <= 1'b0;
                        wr_en_q   <= 1'b0;
                        mem_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= STEADY;
            endcase
        end
    end

    // Address, data and writeback payload registers carry no reset.
    always_ff @(posedge clk) begin
        if (accept_mem) begin
            addr_q  <= alu_result;
            wdata_q <= store_data;
            rd_q    <= rd;
        end
        if (accept_alu) begin
            regwr_sel_q  <= rd;
            regwr_data_q <= alu_result;
        end else if (mem_done) begin
            regwr_sel_q  <= rd_q;
            regwr_data_q <= data_rd_data;
        end
    end

    assign decode_rdy   = (state_q == STEADY);
    assign data_req     = req_q;
    assign data_wr_en   = wr_en_q;
    assign data_addr    = addr_q;
    assign data_wr_data = wdata_q;
    assign regwr_en     = regwr_en_q;
    assign regwr_sel    = regwr_sel_q;
    assign regwr_data   = regwr_data_q;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_kronos_ex_memctrl.sv
// Directed bench for kronos_ex_memctrl with a writeback scoreboard; built with
// WAIT_LIMIT=4 so the timeout path is reachable quickly.
module tb_kronos_ex_memctrl;

    logic        clk;
    logic        rstz;
    logic        decode_vld;
    logic        decode_rdy;
    logic        is_load;
    logic        is_store;
    logic        regwr_alu;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic        data_wr_en;
    logic        data_req;
    logic        data_ack;
    logic [31:0] data_rd_data;
    logic [31:0] regwr_data;
    logic [4:0]  regwr_sel;
    logic        regwr_en;
    logic        mem_err;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  mem_err_seen = 0;

    kronos_ex_memctrl #(.WAIT_LIMIT(4)) dut (
        .clk          (clk),
        .rstz         (rstz),
        .decode_vld   (decode_vld),
        .decode_rdy   (decode_rdy),
        .is_load      (is_load),
        .is_store     (is_store),
        .regwr_alu    (regwr_alu),
        .rd           (rd),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .data_addr    (data_addr),
        .data_wr_data (data_wr_data),
        .data_wr_en   (data_wr_en),
        .data_req     (data_req),
        .data_ack     (data_ack),
        .data_rd_data (data_rd_data),
        .regwr_data   (regwr_data),
        .regwr_sel    (regwr_sel),
        .regwr_en     (regwr_en),
        .mem_err      (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        decode_vld = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        regwr_alu  = 1'b0;
        rd         = 5'd0;
        alu_result = 32'd0;
        store_data = 32'd0;
    endtask

    task automatic issue_mem(input logic ld, input logic st, input logic [4:0] r,
                             input logic [31:0] addr, input logic [31:0] sd);
        decode_vld = 1'b1;
        is_load    = ld;
        is_store   = st;
        regwr_alu  = 1'b0;
        rd         = r;
        alu_result = addr;
        store_data = sd;
        tick();
        idle_inputs();
    endtask

    // Scoreboard: every write strobe must match the oldest expected writeback.
    always @(negedge clk) begin
        if (rstz && regwr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_regwr_en", {27'd0, regwr_sel}, 32'hFFFF_FFFF);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_sel", {27'd0, regwr_sel}, {27'd0, e.sel});
                chk("wb_data", regwr_data, e.data);
            end
        end
        if (rstz && mem_err) mem_err_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstz         = 1'b0;
        data_ack     = 1'b0;
        data_rd_data = 32'd0;
        idle_inputs();
        tick();
        chk("rst_decode_rdy", {31'd0, decode_rdy}, 32'd1);
        chk("rst_data_req", {31'd0, data_req}, 32'd0);
        chk("rst_data_wr_en", {31'd0, data_wr_en}, 32'd0);
        chk("rst_regwr_en", {31'd0, regwr_en}, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        tick();
        rstz = 1'b1;
        tick();

        // ALU writeback, one-cycle latency
        decode_vld = 1'b1; regwr_alu = 1'b1; rd = 5'd5; alu_result = 32'h1234;
        exp_q.push_back('{sel: 5'd5, data: 32'h1234});
        chk("alu_rdy_before", {31'd0, decode_rdy}, 32'd1);
        tick();
        idle_inputs();
        chk("alu_regwr_en", {31'd0, regwr_en}, 32'd1);
        chk("alu_rdy_after", {31'd0, decode_rdy}, 32'd1);
        tick();
        chk("alu_pulse_end", {31'd0, regwr_en}, 32'd0);

        // ALU writeback to x0 is suppressed
        decode_vld = 1'b1; regwr_alu = 1'b1; rd = 5'd0; alu_result = 32'h7777;
        tick();
        idle_inputs();
        chk("alu_rd0_no_wr", {31'd0, regwr_en}, 32'd0);

        // Load acked in first MEM cycle
        exp_q.push_back('{sel: 5'd3, data: 32'hCAFEF00D});
        issue_mem(1'b1, 1'b0, 5'd3, 32'h100, 32'h0);
        chk("ld_req", {31'd0, data_req}, 32'd1);
        chk("ld_addr", data_addr, 32'h100);
        chk("ld_wr_en", {31'd0, data_wr_en}, 32'd0);
        chk("ld_rdy_busy", {31'd0, decode_rdy}, 32'd0);
        data_ack = 1'b1; data_rd_data = 32'hCAFEF00D;
        tick();
        data_ack = 1'b0; data_rd_data = 32'h0;
        chk("ld_req_drop", {31'd0, data_req}, 32'd0);
        chk("ld_regwr_en", {31'd0, regwr_en}, 32'd1);
        chk("ld_rdy_back", {31'd0, decode_rdy}, 32'd1);
        tick();
        chk("ld_pulse_end", {31'd0, regwr_en}, 32'd0);

        // Store with ack after three wait cycles; an ALU op offered meanwhile is ignored
        issue_mem(1'b0, 1'b1, 5'd7, 32'h200, 32'hA5A5A5A5);
        decode_vld = 1'b1; regwr_alu = 1'b1; rd = 5'd9; alu_result = 32'h9999;
        for (int i = 0; i < 4; i++) begin
            chk("st_req", {31'd0, data_req}, 32'd1);
            chk("st_wr_en", {31'd0, data_wr_en}, 32'd1);
            chk("st_rdy_busy", {31'd0, decode_rdy}, 32'd0);
            chk("st_addr", data_addr, 32'h200);
            chk("st_wdata", data_wr_data, 32'hA5A5A5A5);
            if (i == 3) data_ack = 1'b1;
            tick();
            idle_inputs();
        end
        data_ack = 1'b0;
        chk("st_req_drop", {31'd0, data_req}, 32'd0);
        chk("st_no_wr", {31'd0, regwr_en}, 32'd0);
        chk("st_no_err", {31'd0, mem_err}, 32'd0);
        tick();

        // Load timing out after four cycles
        issue_mem(1'b1, 1'b0, 5'd4, 32'h300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("to_req", {31'd0, data_req}, 32'd1);
            chk("to_err_low", {31'd0, mem_err}, 32'd0);
            tick();
        end
        chk("to_mem_err", {31'd0, mem_err}, 32'd1);
        chk("to_req_drop", {31'd0, data_req}, 32'd0);
        chk("to_rdy_back", {31'd0, decode_rdy}, 32'd1);
        chk("to_no_wr", {31'd0, regwr_en}, 32'd0);
        tick();
        chk("to_err_pulse_end", {31'd0, mem_err}, 32'd0);

        // Load acked in the last allowed cycle completes normally
        exp_q.push_back('{sel: 5'd6, data: 32'h11112222});
        issue_mem(1'b1, 1'b0, 5'd6, 32'h304, 32'h0);
        tick(); tick(); tick();
        chk("late_req", {31'd0, data_req}, 32'd1);
        data_ack = 1'b1; data_rd_data = 32'h11112222;
        tick();
        data_ack = 1'b0;
        chk("late_no_err", {31'd0, mem_err}, 32'd0);
        chk("late_regwr_en", {31'd0, regwr_en}, 32'd1);
        tick();

        // Load to x0 produces no writeback
        issue_mem(1'b1, 1'b0, 5'd0, 32'h400, 32'h0);
        data_ack = 1'b1; data_rd_data = 32'h5555AAAA;
        tick();
        data_ack = 1'b0;
        chk("ld_rd0_no_wr", {31'd0, regwr_en}, 32'd0);
        tick();

        // Both kind flags set decodes as a load
        exp_q.push_back('{sel: 5'd8, data: 32'hDEADBEEF});
        issue_mem(1'b1, 1'b1, 5'd8, 32'h500, 32'h12345678);
        chk("both_wr_en", {31'd0, data_wr_en}, 32'd0);
        chk("both_addr", data_addr, 32'h500);
        data_ack = 1'b1; data_rd_data = 32'hDEADBEEF;
        tick();
        data_ack = 1'b0;
        chk("both_regwr_en", {31'd0, regwr_en}, 32'd1);
        tick();

        // Stray ack while idle is ignored
        data_ack = 1'b1; data_rd_data = 32'hBAD0BAD0;
        tick();
        data_ack = 1'b0;
        chk("stray_ack_req", {31'd0, data_req}, 32'd0);
        chk("stray_ack_no_wr", {31'd0, regwr_en}, 32'd0);
        tick();

        // Reset in MEM abandons the transaction asynchronously
        issue_mem(1'b1, 1'b0, 5'd10, 32'h600, 32'h0);
        chk("rstmem_req", {31'd0, data_req}, 32'd1);
        #2 rstz = 1'b0;
        #1;
        chk("rstmem_req_async", {31'd0, data_req}, 32'd0);
        chk("rstmem_rdy", {31'd0, decode_rdy}, 32'd1);
        data_ack = 1'b1; data_rd_data = 32'h0BADF00D;
        tick();
        data_ack = 1'b0;
        rstz = 1'b1;
        tick();
        chk("rstmem_no_err", {31'd0, mem_err}, 32'd0);
        chk("rstmem_no_wr", {31'd0, regwr_en}, 32'd0);
        decode_vld = 1'b1; regwr_alu = 1'b1; rd = 5'd12; alu_result = 32'h55AA;
        exp_q.push_back('{sel: 5'd12, data: 32'h55AA});
        tick();
        idle_inputs();
        chk("post_rst_alu_wr", {31'd0, regwr_en}, 32'd1);
        tick(); tick();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("mem_err_pulses", mem_err_seen, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/kronos_ex_memctrl.md
KRONOS_EX_MEMCTRL -- requirements
Module: kronos_ex_memctrl

Interface
REQ-001 SHALL have parameter: WAIT_LIMIT, 255, max cycles in MEM awaiting data_ack before abort (legal 1..255).
REQ-002 SHALL have a single clock and an asynchronous, active-low reset.
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge
- rstz  in  1  async active-low reset
- decode_vld  in  1  EX instruction valid
- decode_rdy  out  1  controller can accept an instruction
- is_load  in  1  instruction is a word load
- is_store  in  1  instruction is a word store
- regwr_alu  in  1  instruction writes back the ALU result
- rd  in  5  destination register
- alu_result  in  32  ALU result; also the load/store address
- store_data  in  32  store write data
- data_addr  out  32  memory address
- data_wr_data  out  32  memory write data
- data_wr_en  out  1  current request is a write
- data_req  out  1  memory request
- data_ack  in  1  memory completes the request this cycle
- data_rd_data  in  32  load data, valid with data_ack
- regwr_data  out  32  register write data
- regwr_sel  out  5  register write index
- regwr_en  out  1  register write strobe, one cycle
- mem_err  out  1  one-cycle pulse on memory timeout

Function
REQ-004 SHALL implement FSM states STEADY and MEM; decode_rdy = (state == STEADY).
REQ-005 In STEADY, on decode_vld with is_load or is_store, SHALL register: alu_result into data_addr, store_data into data_wr_data, rd, and load/store kind; SHALL then go to MEM with data_req=1 from the next cycle.
REQ-006 If is_load and is_store are both high, SHALL treat the instruction as a load.
REQ-007 In STEADY, on decode_vld with regwr_alu and neither is_load nor is_store, SHALL set regwr_en=1, regwr_sel=rd and regwr_data=alu_result on the next cycle.
REQ-008 SHALL keep regwr_en=0 for any writeback whose rd==0.
REQ-009 In MEM, SHALL hold data_req=1 and keep data_addr and data_wr_data stable; data_wr_en=1 for a store and 0 for a load.
REQ-010 In MEM, on data_ack, SHALL deassert data_req on the next cycle and return to STEADY.
REQ-011 For a load completed by data_ack, SHALL set regwr_en=1, regwr_sel=rd and regwr_data=data_rd_data on the next cycle.
REQ-012 For a store completed by data_ack, SHALL perform no register write.
REQ-013 SHALL count MEM cycles in an 8-bit counter cleared on MEM entry.
REQ-014 If data_ack is absent in the cycle the count equals WAIT_LIMIT-1, SHALL on the next cycle:
- pulse mem_err=1 for one cycle;
- drop data_req and return to STEADY;
- perform no writeback.
REQ-015 data_ack arriving in the timeout cycle SHALL take precedence over the timeout.
REQ-016 SHALL ignore data_ack outside MEM.
REQ-017 SHALL ignore decode_vld while in MEM.
REQ-018 Latency: an ALU writeback SHALL take 1 cycle; a load with ack in the first MEM cycle SHALL write at accept+2; accept-to-accept for back-to-back memory operations SHALL be at least 2 cycles.
REQ-019 regwr_en SHALL be a single-cycle pulse per retired instruction, never asserted on two consecutive cycles for one instruction.

Reset
REQ-020 On rstz low SHALL immediately force: state=STEADY; data_req, data_wr_en, regwr_en and mem_err to 0; counter to 0.
REQ-021 Data/address registers SHALL NOT be reset.
REQ-022 Reset asserted in MEM SHALL abandon the transaction without writeback or mem_err.

Verification
REQ-023 ALU op: decode_vld, regwr_alu=1, rd=5, alu_result=0x1234 -> next cycle regwr_en=1, regwr_sel=5, regwr_data=0x1234; decode_rdy stays 1.
REQ-024 Load: is_load=1, alu_result=0x100, rd=3; ack on first MEM cycle with data_rd_data=0xCAFEF00D -> data_req high for 1 cycle, data_addr=0x100, data_wr_en=0; one cycle later regwr_en=1, sel=3, data=0xCAFEF00D.
REQ-025 Store: is_store=1, addr=0x200, store_data=0xA5A5A5A5; ack delayed 3 cycles -> data_req high for 4 cycles, data_wr_en=1, decode_rdy=0 throughout, no regwr_en.
REQ-026 Timeout with WAIT_LIMIT=4, load and no ack -> data_req high for 4 cycles; then mem_err pulses once, state=STEADY, no regwr_en; ack in the 4th cycle instead -> normal completion, no mem_err.
REQ-027 Corners:
- load with rd=0 -> no regwr_en;
- is_load=is_store=1 -> load;
- rstz low during MEM -> data_req=0 asynchronously; after release decode_rdy=1 and a fresh ALU op writes back normally.
